orv64_ma_load_resp_buf: RTL and testbench
=========================================

// Module: orv64_ma_load_resp_buf
// PURPOSE
//  In-order load-response buffer for the MA stage. Replaces the single dc2ma hold register.
//  Tracks up to DEPTH outstanding D$ loads. Aligns and sign/zero-extends returned data.
//  Holds responses while WB is stalled, and drops late responses after a pipeline flush.
//  Sits between the L1D$ response port and WB / regfile write.
// PARAMETERS
//  DATA_W  64  D$ response width in bits; power of 2, >= 64
//  DEPTH   2   outstanding entries; >= 1, need not be a power of 2
//  TAG_W   5   opaque tag carried per load (rd_addr)
// PORTS
//  clk               in   1              clock
//  rst               in   1              synchronous, active-high reset
//  req_valid         in   1              MA issues a load
//  req_ready         out  1              entry free; equals ~full & ~flush
//  req_addr_lo       in   AW=log2(DATA_W/8)  byte offset within the response word
//  req_size          in   3              log2(bytes); 0..log2(DATA_W/8)
//  req_signed        in   1              1 = sign-extend, 0 = zero-extend
//  req_tag           in   TAG_W          returned with the result
//  dc_req_valid      out  1              = req_valid & req_ready & ~misaligned
//  dc_resp_valid     in   1              D$ response; in order, no backpressure
//  dc_resp_rdata     in   DATA_W         raw response word
//  dc_resp_excp_valid in  1              D$ exception
//  dc_resp_excp_cause in  4              D$ exception cause
//  dc_resp_par       in   DATA_W/8       per-byte even parity; exists only with ORV64_MA_RESP_PARITY_EN
//  flush             in   1              kill all entries (ma_kill / trap)
//  wb_valid          out  1              head entry complete
//  wb_ready          in   1              WB accepts
//  wb_data           out  DATA_W         aligned, extended load data
//  wb_tag            out  TAG_W          tag of the head entry
//  wb_excp_valid     out  1              exception on the head entry
//  wb_excp_cause     out  4              cause for the head entry
// BEHAVIOUR
//  - Reset state
//    - All entries EMPTY; rd/wr pointers = 0; drop_cnt = 0.
//    - wb_valid = 0; req_ready = 1 in the first cycle after reset.
//  - Entry states: EMPTY -> WAIT on req fire. WAIT -> DONE on the matching response.
//    DONE -> EMPTY on wb_valid & wb_ready.
//  - Misaligned load: (req_addr_lo & ((1<<req_size)-1)) != 0.
//    - Entry goes directly to DONE; no D$ request is sent.
//    - Result: excp_valid = 1, cause = LOAD_ADDR_MISALIGNED (4).
//  - Pointers and completion order
//    - Pointers wrap explicitly at DEPTH-1 -> 0.
//    - full = (count == DEPTH); count width = $clog2(DEPTH+1).
//    - A response completes the oldest WAIT entry (wait pointer, wraps like the others).
//  - Data path
//    - Response data is registered into the entry: wb_valid no earlier than the cycle after dc_resp_valid.
//    - Data = rdata >> (addr_lo*8), masked to (8<<size) bits, then extended to DATA_W.
//  - Exception from D$ is stored; the entry's data is don't-care.
//  - Throughput: 1 request + 1 response + 1 retire per cycle.
//    Simultaneous request and retire while full: the request is refused (req_ready = 0).
//  - Flush (takes priority over everything in its cycle)
//    - Every entry -> EMPTY. A request in the same cycle is ignored.
//    - drop_cnt += (#WAIT entries) - (dc_resp_valid ? 1 : 0).
//    - While drop_cnt != 0, each dc_resp_valid decrements drop_cnt and is discarded.
//    - New requests are accepted during draining. Order guarantees the next responses are the stale ones.
//  - wb outputs are stable while wb_valid & ~wb_ready.
//  - Reset mid-operation discards everything, drop_cnt included. The D$ is reset together with this block.
//  - Simulation assertions (SVA, `ifndef SYNTHESIS)
//    - Response with no WAIT entry and drop_cnt == 0.
//    - req_size above log2(DATA_W/8).
//    - drop_cnt overflow.
// CONFIGURATION
//  ORV64_MA_RESP_PARITY_EN
//    - Defined: dc_resp_par is present. Any byte parity mismatch on a non-excepting response
//      sets excp_valid = 1, cause = LOAD_ACCESS_FAULT (5). A D$ exception takes precedence.
//    - Undefined: the port is absent and no check is made.
// STRUCTURE
//  - orv64_typedef_pkg
//    - orv64_lrb_state_e {EMPTY, WAIT, DONE}.
//    - orv64_lrb_entry_t {state, addr_lo, size, signed, tag, data, excp_valid, excp_cause}.
//  - orv64_param_pkg: existing excp cause constants; ORV64_LRB_DEPTH_DEFAULT.
//  - Sub-module orv64_load_align: combinational shift/mask/extend, parametrised by DATA_W.
// TESTING
//  1. lb addr_lo=3, signed, rdata=64'h0000_0000_8000_0000 ->
//     wb_data=64'hFFFF_FFFF_FFFF_FF80, tag echoed, 1 cycle after the response.
//  2. lw addr_lo=2 -> dc_req_valid=0; wb_valid next cycle; excp cause 4.
//  3. DEPTH=2, wb_ready=0, 3 loads -> third sees req_ready=0; both responses held.
//     wb_ready=1 -> results retire in order on 2 consecutive cycles.
//  4. 2 loads WAIT, flush together with one response -> drop_cnt=1.
//     New load issued; next response discarded; the following one returns for the new tag.
//  5. DATA_W=128, ld addr_lo=8, unsigned -> wb_data = rdata[127:64].
//  6. With ORV64_MA_RESP_PARITY_EN: flip par[0] on a clean response -> excp cause 5.
//     Same with dc_resp_excp_valid=1, cause 13 -> reported cause is 13.

Source files
------------

// File: rtl/orv64_ma_load_resp_buf_pkg.sv
// Shared types and constants for the MA-stage load-response buffer.
package orv64_ma_load_resp_buf_pkg;

  localparam int ORV64_LRB_DEPTH_DEFAULT = 2;

  localparam logic [3:0] EXCP_LOAD_ADDR_MISALIGNED = 4'd4;
  localparam logic [3:0] EXCP_LOAD_ACCESS_FAULT    = 4'd5;

  typedef enum logic [1:0] {
    LRB_EMPTY = 2'd0,
    LRB_WAIT  = 2'd1,
    LRB_DONE  = 2'd2
  } orv64_lrb_state_e;

  // Width-independent part of an entry; addr_lo, tag and data live in parametrised arrays.
  typedef struct packed {
    orv64_lrb_state_e state;
    logic [2:0]       size;
    logic             is_signed;
    logic             excp_valid;
    logic [3:0]       excp_cause;
  } orv64_lrb_entry_t;

endpackage

// File: rtl/orv64_load_align.sv
// Combinational load alignment: shift the response word down to the addressed byte, then zero/sign-extend.
module orv64_load_align #(
  parameter  int DATA_W = 64,
  localparam int AW     = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [AW-1:0]     addr_lo,
  input  logic [2:0]        size,
  input  logic              is_signed,
  output logic [DATA_W-1:0] data
);
  logic [DATA_W-1:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    data = shifted;
    for (int s = 0; s <= AW; s++) begin
      if (size == 3'(s)) begin
        for (int i = (8 << s); i < DATA_W; i++) data[i] = is_signed & shifted[(8 << s) - 1];
      end
    end
  end
endmodule

// File: rtl/orv64_ma_load_resp_buf.sv
// In-order load-response buffer between the L1D$ response port and WB.
// Define ORV64_MA_RESP_PARITY_EN to add per-byte even-parity checking of D$ responses.
module orv64_ma_load_resp_buf
  import orv64_ma_load_resp_buf_pkg::*;
#(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = ORV64_LRB_DEPTH_DEFAULT,
  parameter  int TAG_W  = 5,
  localparam int AW     = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AW-1:0]     req_addr_lo,
  input  logic [2:0]        req_size,
  input  logic              req_signed,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              dc_req_valid,
  input  logic              dc_resp_valid,
  input  logic [DATA_W-1:0] dc_resp_rdata,
  input  logic              dc_resp_excp_valid,
  input  logic [3:0]        dc_resp_excp_cause,
`ifdef ORV64_MA_RESP_PARITY_EN
  input  logic [DATA_W/8-1:0] dc_resp_par,
`endif
  input  logic              flush,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [TAG_W-1:0]  wb_tag,
  output logic              wb_excp_valid,
  output logic [3:0]        wb_excp_cause
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = CW + 3;

  orv64_lrb_entry_t [DEPTH-1:0]             ent_q;
  logic [DEPTH-1:0][AW-1:0]                 addr_q;
  logic [DEPTH-1:0][TAG_W-1:0]              tag_q;
  logic [DEPTH-1:0][DATA_W-1:0]             data_q;
  logic [PW-1:0] wr_ptr, rd_ptr, wt_idx;
  logic [CW-1:0] count, n_wait;
  logic [DW-1:0] drop_q, drop_d;
  logic          wt_found, full, misaligned, req_fire, wb_fire, resp_live, complete, par_err;
  logic [DATA_W-1:0] aligned;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full       = (count == CW'(DEPTH));
  assign misaligned = |(req_addr_lo & AW'((32'd1 << req_size) - 32'd1));
  assign req_ready  = ~full & ~flush;
  assign req_fire   = req_valid & req_ready;
  assign dc_req_valid = req_fire & ~misaligned;
  assign wb_valid   = (ent_q[rd_ptr].state == LRB_DONE);
  assign wb_fire    = wb_valid & wb_ready & ~flush;
  assign wb_data    = data_q[rd_ptr];
  assign wb_tag     = tag_q[rd_ptr];
  assign wb_excp_valid = ent_q[rd_ptr].excp_valid;
  assign wb_excp_cause = ent_q[rd_ptr].excp_cause;

  // Oldest WAIT entry in age order from the read pointer; misaligned DONE entries are skipped.
  always_comb begin
    wt_idx   = rd_ptr;
    wt_found = 1'b0;
    n_wait   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      logic [PW:0]   sum;
      logic [PW-1:0] idx;
      sum = {1'b0, rd_ptr} + (PW+1)'(k);
      idx = (sum >= (PW+1)'(DEPTH)) ? PW'(sum - (PW+1)'(DEPTH)) : PW'(sum);
      if (ent_q[idx].state == LRB_WAIT) begin
        n_wait = n_wait + 1'b1;
        if (!wt_found) begin
          wt_found = 1'b1;
          wt_idx   = idx;
        end
      end
    end
  end

`ifdef ORV64_MA_RESP_PARITY_EN
  always_comb begin
    par_err = 1'b0;
    for (int b = 0; b < DATA_W/8; b++) par_err = par_err | (^{dc_resp_rdata[8*b +: 8], dc_resp_par[b]});
  end
`else
  assign par_err = 1'b0;
`endif

  assign resp_live = dc_resp_valid & (drop_q == '0) & ~flush;
  assign complete  = resp_live & wt_found;

  // Responses already in flight at a flush belong to killed entries and must be swallowed.
  always_comb begin
    drop_d = drop_q;
    if (flush) begin
      if (!(dc_resp_valid && drop_q == '0 && n_wait == '0))
        drop_d = drop_q + DW'(n_wait) - DW'(dc_resp_valid);
    end else if (dc_resp_valid && drop_q != '0) begin
      drop_d = drop_q - 1'b1;
    end
  end

  orv64_load_align #(.DATA_W(DATA_W)) u_align (
    .rdata     (dc_resp_rdata),
    .addr_lo   (addr_q[wt_idx]),
    .size      (ent_q[wt_idx].size),
    .is_signed (ent_q[wt_idx].is_signed),
    .data      (aligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) ent_q[i].state <= LRB_EMPTY;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (req_fire) begin
          ent_q[wr_ptr] <= '{state:      misaligned ? LRB_DONE : LRB_WAIT,
                             size:       req_size,
                             is_signed:  req_signed,
                             excp_valid: misaligned,
                             excp_cause: misaligned ? EXCP_LOAD_ADDR_MISALIGNED : 4'd0};
          wr_ptr <= ptr_inc(wr_ptr);
        end
        if (complete) begin
          ent_q[wt_idx].state      <= LRB_DONE;
          ent_q[wt_idx].excp_valid <= dc_resp_excp_valid | par_err;
          ent_q[wt_idx].excp_cause <= dc_resp_excp_valid ? dc_resp_excp_cause :
                                      par_err            ? EXCP_LOAD_ACCESS_FAULT : 4'd0;
        end
        if (wb_fire) begin
          ent_q[rd_ptr].state <= LRB_EMPTY;
          rd_ptr <= ptr_inc(rd_ptr);
        end
        count <= count + CW'(req_fire) - CW'(wb_fire);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire && !flush) begin
      addr_q[wr_ptr] <= req_addr_lo;
      tag_q[wr_ptr]  <= req_tag;
    end
    if (complete) data_q[wt_idx] <= aligned;
  end

`ifndef SYNTHESIS
  logic [DW:0] drop_sum;
  assign drop_sum = {1'b0, drop_q} + (DW+1)'(n_wait);

  a_resp_unexpected: assert property (@(posedge clk) disable iff (rst)
    dc_resp_valid |-> (drop_q != '0) || (n_wait != '0));
  a_size_range: assert property (@(posedge clk) disable iff (rst)
    req_valid |-> (req_size <= 3'(AW)));
  a_drop_ovf: assert property (@(posedge clk) disable iff (rst)
    flush |-> !drop_sum[DW]);
`endif
endmodule

// File: tb/tb_orv64_ma_load_resp_buf.sv
// Directed bench for the load-response buffer: 64-bit/DEPTH=2 instance plus a 128-bit instance.
module tb_orv64_ma_load_resp_buf;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        req_valid, req_ready, req_signed, dc_req_valid;
  logic [2:0]  req_addr_lo, req_size;
  logic [4:0]  req_tag, wb_tag;
  logic        dc_resp_valid, dc_resp_excp_valid, flush, wb_valid, wb_ready, wb_excp_valid;
  logic [63:0] dc_resp_rdata, wb_data;
  logic [3:0]  dc_resp_excp_cause, wb_excp_cause;

  logic         w_req_valid, w_req_ready, w_req_signed, w_dc_req_valid;
  logic [3:0]   w_req_addr_lo;
  logic [2:0]   w_req_size;
  logic [4:0]   w_req_tag, w_wb_tag;
  logic         w_dc_resp_valid, w_wb_valid, w_wb_excp_valid;
  logic [127:0] w_dc_resp_rdata, w_wb_data;
  logic [3:0]   w_wb_excp_cause;

`ifdef ORV64_MA_RESP_PARITY_EN
  logic [7:0]  par_flip;
  logic [7:0]  dc_resp_par;
  logic [15:0] w_dc_resp_par;
  always_comb begin
    for (int b = 0; b < 8; b++)  dc_resp_par[b]   = (^dc_resp_rdata[8*b +: 8]) ^ par_flip[b];
    for (int b = 0; b < 16; b++) w_dc_resp_par[b] = ^w_dc_resp_rdata[8*b +: 8];
  end
`endif

  orv64_ma_load_resp_buf #(.DATA_W(64), .DEPTH(2), .TAG_W(5)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr_lo(req_addr_lo),
    .req_size(req_size), .req_signed(req_signed), .req_tag(req_tag),
    .dc_req_valid(dc_req_valid), .dc_resp_valid(dc_resp_valid), .dc_resp_rdata(dc_resp_rdata),
    .dc_resp_excp_valid(dc_resp_excp_valid), .dc_resp_excp_cause(dc_resp_excp_cause),
`ifdef ORV64_MA_RESP_PARITY_EN
    .dc_resp_par(dc_resp_par),
`endif
    .flush(flush), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_tag(wb_tag), .wb_excp_valid(wb_excp_valid), .wb_excp_cause(wb_excp_cause)
  );

  orv64_ma_load_resp_buf #(.DATA_W(128), .DEPTH(2), .TAG_W(5)) u_dut128 (
    .clk(clk), .rst(rst),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_addr_lo(w_req_addr_lo),
    .req_size(w_req_size), .req_signed(w_req_signed), .req_tag(w_req_tag),
    .dc_req_valid(w_dc_req_valid), .dc_resp_valid(w_dc_resp_valid), .dc_resp_rdata(w_dc_resp_rdata),
    .dc_resp_excp_valid(1'b0), .dc_resp_excp_cause(4'd0),
`ifdef ORV64_MA_RESP_PARITY_EN
    .dc_resp_par(w_dc_resp_par),
`endif
    .flush(1'b0), .wb_valid(w_wb_valid), .wb_ready(1'b1), .wb_data(w_wb_data),
    .wb_tag(w_wb_tag), .wb_excp_valid(w_wb_excp_valid), .wb_excp_cause(w_wb_excp_cause)
  );

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [2:0] a, input logic [2:0] s, input logic sg, input logic [4:0] t);
    req_valid = 1'b1; req_addr_lo = a; req_size = s; req_signed = sg; req_tag = t;
  endtask

  task automatic respond(input logic [63:0] d);
    dc_resp_valid = 1'b1; dc_resp_rdata = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    checks++; if (w_wb_valid !== 1'b0) begin errors++; $display("FAIL reset_w_wb_valid got %b exp 0", w_wb_valid); end
    cyc();
  endtask

  task automatic test_lb_signed();
    issue(3'd3, 3'd0, 1'b1, 5'd7);
    #1;
    checks++; if (dc_req_valid !== 1'b1) begin errors++; $display("FAIL lb_dc_req got %b exp 1", dc_req_valid); end
    cyc();
    req_valid = 1'b0;
    respond(64'h0000_0000_8000_0000);
    #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL lb_early_valid got %b exp 0", wb_valid); end
    cyc();
    dc_resp_valid = 1'b0;
    #1;
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL lb_valid got %b exp 1", wb_valid); end
    checks++; if (wb_data !== 64'hFFFF_FFFF_FFFF_FF80) begin errors++; $display("FAIL lb_data got %h exp ffffffffffffff80", wb_data); end
    checks++; if (wb_tag !== 5'd7) begin errors++; $display("FAIL lb_tag got %0d exp 7", wb_tag); end
    checks++; if (wb_excp_valid !== 1'b0) begin errors++; $display("FAIL lb_excp got %b exp 0", wb_excp_valid); end
    cyc();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL lb_retire got %b exp 0", wb_valid); end
  endtask

  task automatic test_misaligned();
    issue(3'd2, 3'd2, 1'b0, 5'd12);
    #1;
    checks++; if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL mis_dc_req got %b exp 0", dc_req_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mis_ready got %b exp 1", req_ready); end
    cyc();
    req_valid = 1'b0;
    #1;
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL mis_valid got %b exp 1", wb_valid); end
    checks++; if (wb_excp_valid !== 1'b1) begin errors++; $display("FAIL mis_excp got %b exp 1", wb_excp_valid); end
    checks++; if (wb_excp_cause !== 4'd4) begin errors++; $display("FAIL mis_cause got %0d exp 4", wb_excp_cause); end
    checks++; if (wb_tag !== 5'd12) begin errors++; $display("FAIL mis_tag got %0d exp 12", wb_tag); end
    cyc();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL mis_retire got %b exp 0", wb_valid); end
  endtask

  task automatic test_full_hold();
    wb_ready = 1'b0;
    issue(3'd0, 3'd3, 1'b0, 5'd1);
    cyc();
    issue(3'd2, 3'd1, 1'b1, 5'd2);
    cyc();
    issue(3'd0, 3'd3, 1'b0, 5'd3);
    respond(64'h1122_3344_5566_7788);
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", req_ready); end
    checks++; if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL full_dc_req got %b exp 0", dc_req_valid); end
    cyc();
    respond(64'h0000_0000_8001_0000);
    cyc();
    dc_resp_valid = 1'b0;
    req_valid = 1'b0;
    cyc();
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got %b exp 1", wb_valid); end
    checks++; if (wb_data !== 64'h1122_3344_5566_7788 || wb_tag !== 5'd1) begin
      errors++; $display("FAIL hold_head got %h/%0d exp 1122334455667788/1", wb_data, wb_tag); end
    cyc();
    checks++; if (wb_data !== 64'h1122_3344_5566_7788 || wb_tag !== 5'd1) begin
      errors++; $display("FAIL hold_stable got %h/%0d exp 1122334455667788/1", wb_data, wb_tag); end
    wb_ready = 1'b1;
    cyc();
    checks++; if (wb_valid !== 1'b1 || wb_data !== 64'hFFFF_FFFF_FFFF_8001 || wb_tag !== 5'd2) begin
      errors++; $display("FAIL order_second got %b/%h/%0d exp 1/ffffffffffff8001/2", wb_valid, wb_data, wb_tag); end
    cyc();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL order_empty got %b exp 0", wb_valid); end
  endtask

  task automatic test_flush_drop();
    issue(3'd0, 3'd3, 1'b0, 5'd3);
    cyc();
    issue(3'd0, 3'd3, 1'b0, 5'd4);
    cyc();
    issue(3'd0, 3'd3, 1'b0, 5'd5);
    flush = 1'b1;
    respond(64'h0BAD_0BAD_0BAD_0BAD);
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", req_ready); end
    cyc();
    flush = 1'b0;
    dc_resp_valid = 1'b0;
    issue(3'd0, 3'd0, 1'b0, 5'd9);
    #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got %b exp 0", wb_valid); end
    checks++; if (dc_req_valid !== 1'b1) begin errors++; $display("FAIL drain_accept got %b exp 1", dc_req_valid); end
    cyc();
    req_valid = 1'b0;
    respond(64'h0000_0000_0000_00AA);
    cyc();
    respond(64'h0000_0000_0000_0055);
    #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL stale_dropped got %b exp 0", wb_valid); end
    cyc();
    dc_resp_valid = 1'b0;
    #1;
    checks++; if (wb_valid !== 1'b1 || wb_data !== 64'h55 || wb_tag !== 5'd9) begin
      errors++; $display("FAIL drain_new got %b/%h/%0d exp 1/0000000000000055/9", wb_valid, wb_data, wb_tag); end
    cyc();
  endtask

  task automatic test_back_to_back();
    issue(3'd1, 3'd0, 1'b0, 5'd10);
    cyc();
    issue(3'd0, 3'd3, 1'b0, 5'd11);
    respond(64'h0000_0000_0000_FF00);
    #1;
    checks++; if (dc_req_valid !== 1'b1) begin errors++; $display("FAIL b2b_req got %b exp 1", dc_req_valid); end
    cyc();
    req_valid = 1'b0;
    respond(64'hDEAD_BEEF_0123_4567);
    #1;
    checks++; if (wb_valid !== 1'b1 || wb_data !== 64'hFF || wb_tag !== 5'd10) begin
      errors++; $display("FAIL b2b_first got %b/%h/%0d exp 1/00000000000000ff/10", wb_valid, wb_data, wb_tag); end
    cyc();
    dc_resp_valid = 1'b0;
    #1;
    checks++; if (wb_valid !== 1'b1 || wb_data !== 64'hDEAD_BEEF_0123_4567 || wb_tag !== 5'd11) begin
      errors++; $display("FAIL b2b_second got %b/%h/%0d exp 1/deadbeef01234567/11", wb_valid, wb_data, wb_tag); end
    cyc();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", wb_valid); end
  endtask

  task automatic test_wide();
    w_req_valid = 1'b1; w_req_addr_lo = 4'd8; w_req_size = 3'd3; w_req_signed = 1'b0; w_req_tag = 5'd20;
    cyc();
    w_req_addr_lo = 4'd12; w_req_size = 3'd2; w_req_signed = 1'b1; w_req_tag = 5'd21;
    w_dc_resp_valid = 1'b1;
    w_dc_resp_rdata = 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF;
    cyc();
    w_req_valid = 1'b0;
    #1;
    checks++; if (w_wb_valid !== 1'b1 || w_wb_data !== 128'h0000_0000_0000_0000_FEDC_BA98_7654_3210) begin
      errors++; $display("FAIL wide_ld got %b/%h exp 1/0000000000000000fedcba9876543210", w_wb_valid, w_wb_data); end
    cyc();
    w_dc_resp_valid = 1'b0;
    #1;
    checks++; if (w_wb_valid !== 1'b1 || w_wb_data !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FEDC_BA98 || w_wb_tag !== 5'd21) begin
      errors++; $display("FAIL wide_lw got %b/%h/%0d exp 1/fffffffffffffffffffffffffedcba98/21", w_wb_valid, w_wb_data, w_wb_tag); end
    cyc();
  endtask

  task automatic test_reset_mid();
    issue(3'd1, 3'd1, 1'b0, 5'd22);
    cyc();
    req_valid = 1'b0;
    #1;
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got %b exp 1", wb_valid); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    checks++; if (wb_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset got %b/%b exp 0/1", wb_valid, req_ready); end
    cyc();
  endtask

`ifdef ORV64_MA_RESP_PARITY_EN
  task automatic test_parity();
    issue(3'd0, 3'd3, 1'b0, 5'd13);
    cyc();
    issue(3'd0, 3'd3, 1'b0, 5'd14);
    par_flip = 8'h01;
    respond(64'h0123_4567_89AB_CDEF);
    cyc();
    req_valid = 1'b0;
    dc_resp_excp_valid = 1'b1; dc_resp_excp_cause = 4'd13;
    #1;
    checks++; if (wb_excp_valid !== 1'b1 || wb_excp_cause !== 4'd5) begin
      errors++; $display("FAIL par_cause got %b/%0d exp 1/5", wb_excp_valid, wb_excp_cause); end
    cyc();
    dc_resp_valid = 1'b0; dc_resp_excp_valid = 1'b0; par_flip = 8'h00;
    #1;
    checks++; if (wb_excp_valid !== 1'b1 || wb_excp_cause !== 4'd13 || wb_tag !== 5'd14) begin
      errors++; $display("FAIL par_dc_excp got %b/%0d/%0d exp 1/13/14", wb_excp_valid, wb_excp_cause, wb_tag); end
    cyc();
  endtask
`endif

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr_lo = '0; req_size = '0; req_signed = 1'b0; req_tag = '0;
    dc_resp_valid = 1'b0; dc_resp_rdata = '0; dc_resp_excp_valid = 1'b0; dc_resp_excp_cause = '0;
    flush = 1'b0; wb_ready = 1'b1;
    w_req_valid = 1'b0; w_req_addr_lo = '0; w_req_size = '0; w_req_signed = 1'b0; w_req_tag = '0;
    w_dc_resp_valid = 1'b0; w_dc_resp_rdata = '0;
`ifdef ORV64_MA_RESP_PARITY_EN
    par_flip = 8'h00;
`endif
    test_reset();
    test_lb_signed();
    test_misaligned();
    test_full_hold();
    test_flush_drop();
    test_back_to_back();
    test_wide();
    test_reset_mid();
`ifdef ORV64_MA_RESP_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
